// File: rtl/flag_register.sv
// N/Z/V flag register feeding the branch condition evaluator.
// Flags update only on an unstalled commit in RUN; a committed HLT freezes everything until reset.
module flag_register #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          commit,
  input  logic          stall,
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] alu_a,
  input  logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_raw,
  input  logic [DW-1:0] alu_out,
  output logic [2:0]    FLAG,
  output logic [2:0]    flag_next,
  output logic          halted
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t     state_r;
  state_t     state_next_s;
  logic [2:0] flag_r;
  logic [2:0] flag_next_s;
  logic       halted_r;
  logic       upd_s;
  logic       zero_s;
  logic       v_add_s;
  logic       v_sub_s;

  // Overflow comes from the wrap-around result so saturation cannot mask it.
  always_comb begin
    upd_s   = (state_r == RUN) & commit & ~stall;
    zero_s  = (alu_out == {DW{1'b0}});
    v_add_s = (alu_a[DW-1] == alu_b[DW-1]) & (alu_raw[DW-1] != alu_a[DW-1]);
    v_sub_s = (alu_a[DW-1] != alu_b[DW-1]) & (alu_raw[DW-1] != alu_a[DW-1]);
  end

  // Next-state and next-flag decode; unknown opcodes fall to "no change".
  always_comb begin
    state_next_s = state_r;
    flag_next_s  = flag_r;
    if (upd_s) begin
      case (opcode)
        OP_ADD: flag_next_s = {v_add_s, zero_s, alu_out[DW-1]};
        OP_SUB: flag_next_s = {v_sub_s, zero_s, alu_out[DW-1]};
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_next_s[1] = zero_s;
        OP_HLT: state_next_s = HALT;
        default: flag_next_s = flag_r;
      endcase
    end else begin
      flag_next_s = flag_r;
    end
  end

  // State, flag and halted registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= RUN;
      flag_r   <= 3'b000;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      flag_r   <= flag_next_s;
      halted_r <= (state_next_s == HALT);
    end
  end

  assign FLAG      = flag_r;
  assign flag_next = flag_next_s;
  assign halted    = halted_r;

endmodule

// File: tb/tb_flag_register.sv
// Table-driven bench for flag_register with an expected-value queue checked after each edge.
module tb_flag_register;

  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          commit;
  logic          stall;
  logic [3:0]    opcode;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_raw;
  logic [DW-1:0] alu_out;
  logic [2:0]    FLAG;
  logic [2:0]    flag_next;
  logic          halted;

  flag_register #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .commit(commit), .stall(stall), .opcode(opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_raw(alu_raw), .alu_out(alu_out),
    .FLAG(FLAG), .flag_next(flag_next), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          commit;
    logic          stall;
    logic [3:0]    opcode;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] raw;
    logic [DW-1:0] out;
    logic [2:0]    exp_flag;
    logic          exp_halted;
  } vec_t;

  typedef struct {
    logic [2:0] flag;
    logic       halted;
  } exp_t;

  vec_t vecs[16];
  exp_t sb_q[$];
  int   n_vec;
  int   n_err;

  function automatic vec_t mk(input logic c, input logic s, input logic [3:0] op,
                              input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [DW-1:0] raw, input logic [DW-1:0] out,
                              input logic [2:0] ef, input logic eh);
    vec_t v;
    v.commit = c; v.stall = s; v.opcode = op; v.a = a; v.b = b;
    v.raw = raw; v.out = out; v.exp_flag = ef; v.exp_halted = eh;
    return v;
  endfunction

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  // Drive one vector at negedge, check flag_next same cycle, then pop and check after the edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    @(negedge clk);
    commit = v.commit; stall = v.stall; opcode = v.opcode;
    alu_a = v.a; alu_b = v.b; alu_raw = v.raw; alu_out = v.out;
    #1;
    check3($sformatf("flag_next[%0d]", idx), flag_next, v.exp_flag);
    e.flag = v.exp_flag; e.halted = v.exp_halted;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard[%0d]: queue empty", idx);
    end else begin
      got = sb_q.pop_front();
      check3($sformatf("FLAG[%0d]", idx), FLAG, got.flag);
      check1($sformatf("halted[%0d]", idx), halted, got.halted);
    end
  endtask

  initial begin
    logic [2:0] hold_flag;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; commit = 1'b0; stall = 1'b0; opcode = 4'h0;
    alu_a = '0; alu_b = '0; alu_raw = '0; alu_out = '0;

    //          c     s     op     a         b         raw       out       flag    halt
    vecs[0]  = mk(1'b1, 1'b0, 4'h0, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 3'b010, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 16'h7FFF, 3'b100, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 4'h1, 16'h8000, 16'h0001, 16'h7FFF, 16'h8000, 3'b101, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 4'h2, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 3'b111, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 4'h8, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 3'b111, 1'b0);
    vecs[5]  = mk(1'b1, 1'b1, 4'h1, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 3'b111, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 4'h1, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 3'b010, 1'b0);
    vecs[7]  = mk(1'b1, 1'b0, 4'h4, 16'h4000, 16'h0001, 16'h8000, 16'h8000, 3'b000, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0);
    vecs[9]  = mk(1'b1, 1'b0, 4'h1, 16'h0003, 16'h0005, 16'hFFFE, 16'hFFFE, 3'b001, 1'b0);
    vecs[10] = mk(1'b1, 1'b0, 4'h6, 16'h0000, 16'h0003, 16'h0000, 16'h0000, 3'b011, 1'b0);
    vecs[11] = mk(1'b1, 1'b0, 4'h5, 16'h0002, 16'h0001, 16'h0001, 16'h0001, 3'b001, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 4'h0, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000, 3'b101, 1'b0);
    vecs[13] = mk(1'b1, 1'b1, 4'hF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b101, 1'b0);
    vecs[14] = mk(1'b1, 1'b0, 4'hF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b101, 1'b1);
    vecs[15] = mk(1'b1, 1'b0, 4'h0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFE, 3'b101, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check3("reset_FLAG", FLAG, 3'b000);
    check1("reset_halted", halted, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) apply(vecs[i], i);

    // Asynchronous reset mid-cycle clears state without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check3("async_rst_FLAG", FLAG, 3'b000);
    check1("async_rst_halted", halted, 1'b0);

    // Reset held across an edge overrides a flag-setting commit.
    commit = 1'b1; stall = 1'b0; opcode = 4'h0;
    alu_a = 16'h7FFF; alu_b = 16'h0001; alu_raw = 16'h8000; alu_out = 16'h7FFF;
    @(posedge clk);
    #1;
    check3("rst_override_FLAG", FLAG, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    apply(mk(1'b1, 1'b0, 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 16'h7FFF, 3'b100, 1'b0), 16);

    // Ten idle cycles with random ALU inputs: flags must hold.
    hold_flag = 3'b100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      commit = 1'b0; stall = 1'($urandom_range(0, 1)); opcode = 4'($urandom_range(0, 15));
      alu_a = 16'($urandom); alu_b = 16'($urandom); alu_raw = 16'($urandom); alu_out = 16'($urandom);
      #1;
      check3($sformatf("idle_flag_next[%0d]", i), flag_next, hold_flag);
      @(posedge clk);
      #1;
      check3($sformatf("idle_FLAG[%0d]", i), FLAG, hold_flag);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flag_register.md
Name: flag_register

Overview:
- Producer end of the FLAG bus that the next-PC/branch logic consumes.
- Computes N, Z and V from the committing ALU instruction and holds them in a register across non-flag-setting instructions.
- Freezes all state once HLT commits.
- Sits between ALU/commit logic and the branch condition evaluator in the single-cycle datapath.

Parameters:
- DW, 16, datapath width of operands and results.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- commit  input  1  current instruction retires this cycle
- stall  input  1  hold all state regardless of commit
- opcode  input  4  opcode of committing instruction
- alu_a  input  DW  ALU operand A
- alu_b  input  DW  ALU operand B, as presented before any subtract inversion
- alu_raw  input  DW  unsaturated wrap-around A+B or A-B result
- alu_out  input  DW  final ALU result written to the register file (saturated for ADD/SUB)
- FLAG  output  3  registered flags: bit0=N, bit1=Z, bit2=V
- flag_next  output  3  combinational value FLAG will take at the next edge
- halted  output  1  sticky, high once HLT has committed

Behaviour:
- Reset (rst_n low, asynchronous):
  - FLAG=3'b000, halted=0, FSM=RUN.
  - Reset mid-operation overrides any commit on that edge.
- FSM states:
  - RUN: normal operation.
  - HALT: entered on the edge where commit=1, stall=0, opcode=4'b1111. FLAG and halted then hold until rst_n.
  - No other exit from HALT.
- Update condition: upd = (state==RUN) & commit & ~stall.
  - When upd=0, flag_next=FLAG and FLAG holds.
  - stall=1 with commit=1: nothing updates, including HALT entry.
- Per-opcode update when upd=1 (unlisted bits hold their value):
  - 0000 ADD:
    - N = alu_out[DW-1]
    - Z = (alu_out==0)
    - V = (alu_a[DW-1]==alu_b[DW-1]) & (alu_raw[DW-1]!=alu_a[DW-1])
  - 0001 SUB (A-B):
    - N and Z as for ADD.
    - V = (alu_a[DW-1]!=alu_b[DW-1]) & (alu_raw[DW-1]!=alu_a[DW-1])
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: Z = (alu_out==0) only; N and V hold.
  - All other opcodes (RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT): no flag change.
- Latency:
  - flag_next is valid in the same cycle as commit.
  - FLAG reflects it after one edge, so a branch committing in cycle t+1 sees flags from the instruction committed at t.
- Saturated ADD/SUB sets V=1 while N and Z follow the saturated alu_out (0x7FFF gives N=0, Z=0; 0x8000 gives N=1, Z=0).
- Wrap-around: V is derived from alu_raw only and never from alu_out.
- halted = (state==HALT), registered.
- No X propagation: an unknown opcode decodes to "no change".

Test Plan:
- Reset then ADD with a=0x0001, b=0xFFFF, raw=out=0x0000, commit=1 -> after the edge FLAG=3'b010 (Z=1, N=0, V=0).
- ADD a=0x7FFF, b=0x0001, raw=0x8000, out=0x7FFF -> FLAG=3'b100 (V=1, N=0, Z=0). Then SUB a=0x8000, b=0x0001, raw=0x7FFF, out=0x8000 -> FLAG=3'b101.
- From FLAG=3'b101, XOR with out=0x0000 -> FLAG=3'b111 (Z set, N and V held). Then LW with any data -> FLAG stays 3'b111.
- SUB producing out=0x0000 with stall=1 and commit=1 -> FLAG unchanged, flag_next==FLAG. Deassert stall -> FLAG=3'b010 next edge.
- Commit HLT -> halted=1 next edge. Subsequent ADD producing a nonzero negative result -> FLAG and halted unchanged. Pulse rst_n low mid-cycle -> FLAG=000 and halted=0 immediately, without waiting for a clock edge.
- commit=0 with arbitrary ALU inputs for 10 cycles -> FLAG constant and flag_next==FLAG throughout.
